mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences the single memory port shared by the instruction-cache read path, the data-cache miss read path and the write queue drain path. It sits between the caches/write queue and the RAM/bus interface. It grants one transaction at a time and holds the grant until the memory reports completion. It enforces read-after-write ordering against queued dirty writebacks and bounds instruction-fetch starvation.

## Interface
- STARVE_LIMIT, 8: cycles an outstanding icache request may wait before it takes priority over dcache reads.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  icache read request; held until its completion cycle.
- iaddr  in  32  icache read address.
- dmissREN  in  1  dcache miss read request; held until its completion cycle.
- dmissaddr  in  32  dcache miss address.
- dqueueWEN  in  1  write queue has a head entry to drain.
- full  in  1  write queue full.
- dqueue_match  in  1  dmissaddr matches a queued entry (from write queue).
- wdaddr, dstore  in  32 each  write queue head address/data.
- ramready  in  1  memory completes the current access this cycle.
- ramload  in  32  memory read data.
- ramREN, ramWEN  out  1 each  memory strobes.
- ramaddr, ramstore  out  32 each  memory address/write data.
- iwait, dwait, wq_dwait  out  1 each  per-requester wait; low only in the completion cycle.
- iload, dload  out  32 each  ramload passthrough.

## Operation
- FSM states: IDLE, IREAD, DREAD, WDRAIN; reset state IDLE.
- IDLE grant priority, evaluated on the registered state each cycle:
  1. full && dqueueWEN -> WDRAIN.
  2. iREN && istarve == STARVE_LIMIT -> IREAD.
  3. dmissREN && dqueue_match && dqueueWEN -> WDRAIN. This drains the queue until the match clears.
  4. dmissREN -> DREAD.
  5. iREN -> IREAD.
  6. dqueueWEN -> WDRAIN.
  7. Otherwise stay in IDLE.
- IREAD/DREAD/WDRAIN: stay until ramready = 1, then return to IDLE. There is always one IDLE bubble between grants, so a completed requester can drop its request.
- Outputs are Moore on state:
  - IREAD: ramREN = 1, ramaddr = iaddr.
  - DREAD: ramREN = 1, ramaddr = dmissaddr.
  - WDRAIN: ramWEN = 1, ramaddr = wdaddr, ramstore = dstore.
  - IDLE: strobes 0, ramaddr = 0, ramstore = 0.
- Waits:
  - iwait = !(state==IREAD && ramready).
  - dwait = !(state==DREAD && ramready).
  - wq_dwait = !(state==WDRAIN && ramready). The queue pops its head on wq_dwait = 0.
- iload = dload = ramload, combinational.
- istarve counter, width $clog2(STARVE_LIMIT+1):
  - Clears when iREN = 0, or when state==IREAD.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Requests that drop while not granted are simply not granted. No state is kept for them.

## Timing
- Reset values: state IDLE, istarve 0. With state IDLE: ramREN = ramWEN = 0, ramaddr = ramstore = 0, iwait = dwait = wq_dwait = 1.
- RST in any state forces IDLE at the next edge. An in-flight access is abandoned, with strobes low from the following cycle. RST has priority over ramready.
- Latency:
  - Request seen in IDLE at edge t; strobes are valid in cycle t+1.
  - Minimum access is 2 cycles (grant + ramready in the first granted cycle), plus 1 IDLE bubble.
- ramready in IDLE is ignored.
- Full queue with dmissREN and saturated starvation: rule 1 wins, so the drain goes first.
- dqueue_match = 1 with dqueueWEN = 0 is treated as no conflict (rule 4).
- istarve must not advance while its IREAD is in progress.

## Test plan
- Reset: RST high for 2 cycles, with all requests high -> all strobes 0, all waits 1, state IDLE. Release -> first grant is WDRAIN if full=1, otherwise DREAD.
- Single read: iREN = 1, iaddr = 0x40, ramready asserted 3 cycles after the grant -> ramREN and ramaddr = 0x40 for 3 cycles. iwait = 0 only in the third cycle, iload = ramload. Then 1 IDLE cycle.
- RAW ordering: dqueueWEN = 1, dqueue_match = 1, dmissREN = 1 at 0x80 -> WDRAIN with wdaddr/dstore on the port. After the pop, match drops to 0 -> DREAD at 0x80 after the bubble.
- Starvation: iREN and dmissREN held continuously, ramready every cycle, STARVE_LIMIT = 8 -> IREAD is granted once istarve reaches 8, before the next DREAD, and istarve then returns to 0.
- Full queue: full = 1, dqueueWEN = 1, iREN and dmissREN high, istarve saturated -> WDRAIN granted first.
- Reset mid-access: RST in the second cycle of DREAD -> strobes 0 from the next cycle, dwait stays 1. No grant while RST is high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between three requesters: the icache read path,
// the dcache miss read path and the write queue drain path. One transaction
// is granted at a time and held until the memory signals completion with
// ramready. Every grant is followed by one IDLE cycle, so a requester that
// has just completed can drop its request before arbitration runs again.
//
// Ordering and fairness:
//   - A dcache miss that hits a queued dirty line drains the write queue
//     first (read-after-write ordering).
//   - A full write queue always drains first.
//   - An icache request waiting STARVE_LIMIT cycles beats dcache reads.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         icache read request / address
//   dmissREN, dmissaddr dcache miss read request / address
//   dqueueWEN           write queue has a head entry to drain
//   full                write queue full
//   dqueue_match        dmissaddr matches a queued write entry
//   wdaddr, dstore      write queue head address / data
//   ramready            memory completes the current access this cycle
//   ramload             memory read data
//   ramREN, ramWEN      memory read / write strobes
//   ramaddr, ramstore   memory address / write data
//   iwait, dwait        icache / dcache wait, low only in completion cycle
//   wq_dwait            write queue wait, low in completion cycle (pops head)
//   iload, dload        read data passthrough to the caches

module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dmissREN,
    input  logic [31:0] dmissaddr,
    input  logic        dqueueWEN,
    input  logic        full,
    input  logic        dqueue_match,
    input  logic [31:0] wdaddr,
    input  logic [31:0] dstore,
    input  logic        ramready,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        iwait,
    output logic        dwait,
    output logic        wq_dwait,
    output logic [31:0] iload,
    output logic [31:0] dload
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IREAD  = 2'd1;
    localparam logic [1:0] DREAD  = 2'd2;
    localparam logic [1:0] WDRAIN = 2'd3;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [CW-1:0] istarve;

    // Grant selection. Arbitration only happens in IDLE; a granted access
    // always returns to IDLE on completion, which produces the bubble cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (full && dqueueWEN)
                    next_state = WDRAIN;
                else if (iREN && istarve == LIMIT)
                    next_state = IREAD;
                else if (dmissREN && dqueue_match && dqueueWEN)
                    // Keep draining until the conflicting entry has left.
                    next_state = WDRAIN;
                else if (dmissREN)
                    next_state = DREAD;
                else if (iREN)
                    next_state = IREAD;
                else if (dqueueWEN)
                    next_state = WDRAIN;
                else
                    next_state = IDLE;
            end
            IREAD, DREAD, WDRAIN: begin
                if (ramready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            istarve <= '0;
        end else begin
            state <= next_state;
            // The counter measures how long an icache request has been
            // waiting, so it is frozen at zero while that request is served.
            if (!iREN || state == IREAD)
                istarve <= '0;
            else if (istarve != LIMIT)
                istarve <= istarve + CW'(1);
        end
    end

    // Moore outputs: the port reflects only the registered grant.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state)
            IREAD: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DREAD: begin
                ramREN  = 1'b1;
                ramaddr = dmissaddr;
            end
            WDRAIN: begin
                ramWEN   = 1'b1;
                ramaddr  = wdaddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait    = !(state == IREAD  && ramready);
    assign dwait    = !(state == DREAD  && ramready);
    assign wq_dwait = !(state == WDRAIN && ramready);

    assign iload = ramload;
    assign dload = ramload;

endmodule
